// File: rtl/mix_scheduler.sv
// rtl/mix_scheduler.sv - per-tick voice mixer: polls enabled voices, sums, saturates, pushes one stereo sample.
module mix_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 32,
  parameter int TIMEOUT    = 255,
  localparam int IDX_W     = $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  tick,
  input  logic [NUM_VOICES-1:0] voice_en,
  output logic                  voice_req,
  output logic [IDX_W-1:0]      voice_idx,
  input  logic                  voice_valid,
  input  logic [SAMPLE_W-1:0]   voice_l,
  input  logic [SAMPLE_W-1:0]   voice_r,
  output logic [2*SAMPLE_W-1:0] sample,
  output logic                  wrreq,
  input  logic                  wrfull,
  output logic                  busy,
  output logic [15:0]           overrun_cnt,
  output logic                  err_timeout
);

  localparam int AW = SAMPLE_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VOICES - 1);
  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic signed [AW-1:0] MAX_V = {{(IDX_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(IDX_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, SAT, WRITE} state_t;

  state_t                 state, next;
  logic [IDX_W-1:0]       idx;
  logic [7:0]             wait_cnt;
  logic signed [AW-1:0]   acc_l, acc_r;
  logic                   last, wait_done;

  function automatic logic [SAMPLE_W-1:0] clamp(input logic signed [AW-1:0] v);
    if (v > MAX_V)      return {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (v < MIN_V) return {1'b1, {(SAMPLE_W-1){1'b0}}};
    else                return v[SAMPLE_W-1:0];
  endfunction

  assign last      = (idx == LAST_IDX);
  assign wait_done = (wait_cnt == WAIT_LAST);
  assign voice_idx = idx;

  always_comb begin
    next      = state;
    voice_req = 1'b0;
    wrreq     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (tick) next = SCAN;
      SCAN: begin
        if (voice_en[idx]) next = REQ;
        else if (last)     next = SAT;
      end
      REQ: begin
        voice_req = 1'b1;
        next      = WAIT;
      end
      WAIT:  if (voice_valid || wait_done) next = last ? SAT : SCAN;
      SAT:   next = WRITE;
      WRITE: begin
        wrreq = ~wrfull;
        if (!wrfull) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state       <= IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      sample      <= '0;
      overrun_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= next;
      // Any tick we cannot start a frame on is dropped and counted.
      if (tick && state != IDLE && overrun_cnt != 16'hFFFF)
        overrun_cnt <= overrun_cnt + 16'd1;
      case (state)
        IDLE: if (tick) begin
          acc_l <= '0;
          acc_r <= '0;
          idx   <= '0;
        end
        SCAN: if (!voice_en[idx] && !last) idx <= idx + IDX_W'(1);
        WAIT: begin
          if (voice_valid) begin
            acc_l    <= acc_l + {{IDX_W{voice_l[SAMPLE_W-1]}}, voice_l};
            acc_r    <= acc_r + {{IDX_W{voice_r[SAMPLE_W-1]}}, voice_r};
            wait_cnt <= '0;
            if (!last) idx <= idx + IDX_W'(1);
          end else if (wait_done) begin
            err_timeout <= 1'b1;
            wait_cnt    <= '0;
            if (!last) idx <= idx + IDX_W'(1);
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        SAT: sample <= {clamp(acc_l), clamp(acc_r)};
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mix_scheduler.md
MIX_SCHEDULER -- requirements
Module: mix_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_VOICES, default 4, giving the number of voice sources (2..16).
REQ-002 The block SHALL have parameter SAMPLE_W, default 32, giving the signed width of each channel sample.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the maximum WAIT cycles per voice (1..255).
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port aclr, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port tick, input, 1: one-cycle sample-period strobe.
REQ-007 The block SHALL have port voice_en, input, NUM_VOICES: per-voice enable mask.
REQ-008 The block SHALL have port voice_req, output, 1: one-cycle request to the voice engine.
REQ-009 The block SHALL have port voice_idx, output, clog2(NUM_VOICES): index of the voice requested.
REQ-010 The block SHALL have port voice_valid, input, 1: voice engine response strobe.
REQ-011 The block SHALL have ports voice_l and voice_r, input, SAMPLE_W each: signed left/right responses.
REQ-012 The block SHALL have port sample, output, 2*SAMPLE_W: {L,R}, with L in the upper half; drives the audio_out sample input.
REQ-013 The block SHALL have port wrreq, output, 1: FIFO write strobe to audio_out.
REQ-014 The block SHALL have port wrfull, input, 1: audio_out FIFO full.
REQ-015 The block SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-016 The block SHALL have port overrun_cnt, output, 16: count of dropped ticks.
REQ-017 The block SHALL have port err_timeout, output, 1: sticky flag set when a voice fails to respond.

Function
REQ-018 The FSM SHALL have states IDLE, SCAN, REQ, WAIT, SAT, WRITE.
REQ-019 IDLE: on tick, the block SHALL clear acc_l/acc_r, set idx=0 and go to SCAN; with no tick it SHALL stay in IDLE.
REQ-020 SCAN: one cycle per voice; if voice_en[idx]=1, go to REQ; else if idx=NUM_VOICES-1, go to SAT; else idx++ and stay in SCAN.
REQ-021 REQ: voice_req=1 for exactly this cycle with voice_idx=idx, then go to WAIT; voice_idx SHALL hold its value through WAIT.
REQ-022 WAIT: when voice_valid=1, the block SHALL add sign-extended voice_l/voice_r to acc_l/acc_r, clear the wait counter, and advance (to SAT if idx=NUM_VOICES-1, else idx++ and go to SCAN).
REQ-023 The block SHALL ignore voice_valid outside WAIT.
REQ-024 WAIT timeout: after TIMEOUT cycles without voice_valid, the block SHALL add 0, set err_timeout=1 and advance as in REQ-022.
REQ-025 Accumulators SHALL be signed, SAMPLE_W+clog2(NUM_VOICES) bits, and SHALL never overflow.
REQ-026 SAT: each channel SHALL be clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1] and registered into sample; then go to WRITE.
REQ-027 WRITE: wrreq SHALL equal ~wrfull (combinational), be high for exactly one cycle, and the state SHALL return to IDLE in the following cycle.
REQ-028 WRITE: while wrfull=1 the block SHALL hold the state with wrreq=0 and sample stable.
REQ-029 sample SHALL change only on SAT exit.
REQ-030 A tick arriving in any state other than IDLE SHALL be dropped, and overrun_cnt SHALL increment, saturating at 0xFFFF.
REQ-031 A tick in the WRITE cycle where wrreq=1 SHALL count as an overrun.
REQ-032 voice_en SHALL be sampled live in SCAN; changes mid-frame SHALL affect only voices not yet scanned.
REQ-033 Latency with all voices disabled: tick sampled at edge 0 -> SCAN cycles 1..NUM_VOICES -> SAT at NUM_VOICES+1 -> wrreq at NUM_VOICES+2.

Reset
REQ-034 While aclr=1, the block SHALL force state=IDLE and idx=0, and hold voice_req, wrreq, busy, err_timeout, sample, overrun_cnt, acc_l, acc_r and the wait counter at 0, regardless of clk.
REQ-035 An aclr during any state SHALL abort the frame with no wrreq and no voice_req.
REQ-036 err_timeout and overrun_cnt SHALL clear only on aclr.
REQ-037 After aclr deasserts, the first tick SHALL be honoured normally.

Verification
REQ-038 The bench SHALL cover: aclr pulse mid-WAIT -> all outputs 0 next cycle; no wrreq afterwards until a new tick.
REQ-039 The bench SHALL cover: voice_en=0000, tick -> wrreq high exactly 6 cycles later with sample=64'h0, then busy=0.
REQ-040 The bench SHALL cover: voice_en=0011, engine replies L=1024, R=4000 two cycles after each voice_req -> voice_idx 0 then 1; sample[63:32]=2048, sample[31:0]=8000.
REQ-041 The bench SHALL cover: voice_en=1111, all L=32'h7FFFFFFF, R=32'h80000000 -> sample={32'h7FFFFFFF, 32'h80000000}.
REQ-042 The bench SHALL cover: wrfull=1 for 10 cycles in WRITE, plus one tick during that time -> wrreq=0 and sample stable throughout; wrreq=1 in the first cycle wrfull=0; overrun_cnt=1.
REQ-043 The bench SHALL cover: voice_en=0001, voice engine silent -> WAIT lasts 255 cycles, err_timeout=1, then sample=0 is written.
